// File: rtl/pm_domain_seq.sv
// Power-gating sequencer for one switchable domain.
// Orders clock gate, isolation, retention and switch enable.
module pm_domain_seq #(
  parameter int unsigned ISO_CYC     = 4,
  parameter int unsigned SAVE_CYC    = 2,
  parameter int unsigned RESTORE_CYC = 2,
  parameter int unsigned ACK_TIMEOUT = 256,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pd_req_i,
  input  logic pu_req_i,
  input  logic err_clr_i,
  input  logic pwr_ack_i,
  output logic clk_en_o,
  output logic iso_en_o,
  output logic ret_save_o,
  output logic ret_restore_o,
  output logic pwr_sw_en_o,
  output logic busy_o,
  output logic domain_on_o,
  output logic done_o,
  output logic err_o
);

  localparam int unsigned MAX_A =
    (ISO_CYC > SAVE_CYC) ? ISO_CYC : SAVE_CYC;
  localparam int unsigned MAX_B =
    (RESTORE_CYC > ACK_TIMEOUT) ? RESTORE_CYC : ACK_TIMEOUT;
  localparam int unsigned MAX_CYC =
    (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned TW = $clog2(MAX_CYC) + 1;

  typedef logic [TW-1:0] tmr_t;

  localparam tmr_t ISO_LD  = tmr_t'(ISO_CYC - 1);
  localparam tmr_t SAVE_LD = tmr_t'(SAVE_CYC - 1);
  localparam tmr_t REST_LD = tmr_t'(RESTORE_CYC - 1);
  localparam tmr_t ACK_LD  = tmr_t'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_ON,
    S_CLK_OFF,
    S_ISO,
    S_SAVE,
    S_SW_OFF,
    S_OFF,
    S_SW_ON,
    S_RESTORE,
    S_DE_ISO,
    S_CLK_ON
  } state_e;

  state_e state_q, state_d;
  tmr_t   tmr_q, tmr_d, ld_val;
  logic   tmr_zero;
  logic   err_set;
  logic   ack_sync;

  logic [SYNC_STAGES-1:0] sync_q;

  logic clk_en_d, iso_d, save_d, rest_d, sw_d;
  logic busy_d, on_d, done_d, err_d;

  // Bring the switch-chain ack into the always-on clock domain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwr_ack_i};
    end
  end

  assign ack_sync = sync_q[SYNC_STAGES-1];
  assign tmr_zero = (tmr_q == '0);

  // Timer value loaded when a state is entered.
  always_comb begin
    ld_val = '0;
    unique case (state_d)
      S_ISO:     ld_val = ISO_LD;
      S_SAVE:    ld_val = SAVE_LD;
      S_SW_OFF:  ld_val = ACK_LD;
      S_SW_ON:   ld_val = ACK_LD;
      S_RESTORE: ld_val = REST_LD;
      S_DE_ISO:  ld_val = ISO_LD;
      default:   ld_val = '0;
    endcase
  end

  // Next-state, timer and error-set logic.
  always_comb begin
    state_d = state_q;
    err_set = 1'b0;
    tmr_d   = tmr_zero ? tmr_q : tmr_q - tmr_t'(1);
    unique case (state_q)
      S_ON: begin
        if (pd_req_i) state_d = S_CLK_OFF;
      end
      S_CLK_OFF: begin
        state_d = S_ISO;
      end
      S_ISO: begin
        if (tmr_zero) state_d = S_SAVE;
      end
      S_SAVE: begin
        if (tmr_zero) state_d = S_SW_OFF;
      end
      S_SW_OFF: begin
        if (!ack_sync) begin
          state_d = S_OFF;
        end else if (tmr_zero) begin
          err_set = 1'b1;
          state_d = S_SW_ON;
        end
      end
      S_OFF: begin
        if (pu_req_i) state_d = S_SW_ON;
      end
      S_SW_ON: begin
        if (ack_sync) begin
          state_d = S_RESTORE;
        end else if (tmr_zero) begin
          err_set = 1'b1;
          tmr_d   = ACK_LD;
        end
      end
      S_RESTORE: begin
        if (tmr_zero) state_d = S_DE_ISO;
      end
      S_DE_ISO: begin
        if (tmr_zero) state_d = S_CLK_ON;
      end
      S_CLK_ON: begin
        state_d = S_ON;
      end
      default: begin
        state_d = S_ON;
      end
    endcase
    if (state_d != state_q) tmr_d = ld_val;
  end

  // Output decode of the upcoming state, so outputs are flops.
  always_comb begin
    clk_en_d = 1'b0;
    iso_d    = 1'b1;
    save_d   = 1'b0;
    rest_d   = 1'b0;
    sw_d     = 1'b1;
    unique case (state_d)
      S_ON: begin
        clk_en_d = 1'b1;
        iso_d    = 1'b0;
      end
      S_CLK_OFF: iso_d = 1'b0;
      S_ISO:     iso_d = 1'b1;
      S_SAVE:    save_d = 1'b1;
      S_SW_OFF:  sw_d = 1'b0;
      S_OFF:     sw_d = 1'b0;
      S_SW_ON:   sw_d = 1'b1;
      S_RESTORE: rest_d = 1'b1;
      S_DE_ISO:  iso_d = 1'b0;
      S_CLK_ON: begin
        clk_en_d = 1'b1;
        iso_d    = 1'b0;
      end
      default: begin
        clk_en_d = 1'b1;
        iso_d    = 1'b0;
      end
    endcase
    on_d   = (state_d == S_ON);
    busy_d = !(state_d == S_ON || state_d == S_OFF);
    done_d = (state_d != state_q) &&
             (state_d == S_ON || state_d == S_OFF);
    err_d  = err_set | (err_o & ~err_clr_i);
  end

  // State, timer and registered outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_ON;
      tmr_q         <= '0;
      clk_en_o      <= 1'b1;
      iso_en_o      <= 1'b0;
      ret_save_o    <= 1'b0;
      ret_restore_o <= 1'b0;
      pwr_sw_en_o   <= 1'b1;
      busy_o        <= 1'b0;
      domain_on_o   <= 1'b1;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmr_q         <= tmr_d;
      clk_en_o      <= clk_en_d;
      iso_en_o      <= iso_d;
      ret_save_o    <= save_d;
      ret_restore_o <= rest_d;
      pwr_sw_en_o   <= sw_d;
      busy_o        <= busy_d;
      domain_on_o   <= on_d;
      done_o        <= done_d;
      err_o         <= err_d;
    end
  end

endmodule

// File: doc/pm_domain_seq.md
Name: pm_domain_seq

Overview:
- Power-gating sequencer for one switchable domain built from the C28SOI PM control cells (switch chain, isolation, retention).
- Converts single-cycle power-down/power-up requests into the ordered sequence: clock gate, isolation, retention save/restore, and switch enable.
- Waits on the switch-chain acknowledge between steps and detects ack timeouts.
- One instance per domain, placed in the always-on region, driven by the SoC power-management registers.

Parameters:
- ISO_CYC, 4: cycles isolation is held before save, and after de-isolation before clock enable; must be >=1.
- SAVE_CYC, 2: cycles ret_save_o is held high; must be >=1.
- RESTORE_CYC, 2: cycles ret_restore_o is held high; must be >=1.
- ACK_TIMEOUT, 256: maximum cycles to wait for the synchronised switch ack; must be >=2.
- SYNC_STAGES, 2: flip-flop stages on pwr_ack_i; must be >=2.

Ports:
- clk_i, input, 1: always-on clock.
- rst_ni, input, 1: asynchronous active-low reset.
- pd_req_i, input, 1: power-down request pulse; acted on only in ON.
- pu_req_i, input, 1: power-up request pulse; acted on only in OFF.
- err_clr_i, input, 1: clears err_o.
- pwr_ack_i, input, 1: asynchronous ack from the end of the switch chain; 1 means the domain is powered.
- clk_en_o, output, 1: domain clock-gate enable.
- iso_en_o, output, 1: isolation enable; 1 means isolated.
- ret_save_o, output, 1: retention save strobe level.
- ret_restore_o, output, 1: retention restore strobe level.
- pwr_sw_en_o, output, 1: switch-chain enable; 1 means on.
- busy_o, output, 1: 1 in every state except ON and OFF.
- domain_on_o, output, 1: 1 only in ON.
- done_o, output, 1: one-cycle pulse on entering ON or OFF (not on reset).
- err_o, output, 1: sticky ack-timeout flag.

Behaviour:
- All outputs are registered and decoded from the state.
- Reset values:
  - State ON.
  - clk_en_o=1, pwr_sw_en_o=1, domain_on_o=1.
  - iso_en_o=0, ret_save_o=0, ret_restore_o=0.
  - busy_o=0, done_o=0, err_o=0.
  - Synchroniser flops reset to 1.
  - Timer reset to 0.
- Single down-counting timer, width clog2(max(ISO_CYC, SAVE_CYC, RESTORE_CYC, ACK_TIMEOUT))+1. It is loaded on every state entry.
- Outputs per state:
  - ON: clk_en=1, iso=0, sw_en=1.
  - CLK_OFF: clk_en=0.
  - ISO: clk_en=0, iso=1.
  - SAVE: iso=1, ret_save=1.
  - SW_OFF: iso=1, sw_en=0.
  - OFF: iso=1, sw_en=0, clk_en=0.
  - SW_ON: iso=1, sw_en=1.
  - RESTORE: iso=1, sw_en=1, ret_restore=1.
  - DE_ISO: iso=0, clk_en=0.
  - CLK_ON: clk_en=1.
- Transitions:
  - ON: pd_req_i=1 -> CLK_OFF.
  - CLK_OFF: after 1 cycle -> ISO.
  - ISO: after ISO_CYC cycles -> SAVE.
  - SAVE: after SAVE_CYC cycles -> SW_OFF.
  - SW_OFF: ack_sync==0 -> OFF. Timer expiry after ACK_TIMEOUT cycles -> set err_o, then SW_ON (abort and recover power).
  - OFF: pu_req_i=1 -> SW_ON.
  - SW_ON: ack_sync==1 -> RESTORE. Timer expiry -> set err_o and stay in SW_ON with the timer reloaded. Still advances when ack later arrives.
  - RESTORE: after RESTORE_CYC cycles -> DE_ISO.
  - DE_ISO: after ISO_CYC cycles -> CLK_ON.
  - CLK_ON: after 1 cycle -> ON.
- Request handling:
  - Requests arriving in any other state are dropped; no queuing.
  - pd_req_i and pu_req_i high together: only the one valid for the current state is honoured.
- Ack path: ack_sync is pwr_ack_i after SYNC_STAGES flops. Ack latency from the switch response to the state change is SYNC_STAGES+1 cycles.
- err_o:
  - Set and clear in the same cycle: set wins.
  - Stays set across ON/OFF transitions until err_clr_i or reset.
- done_o: pulses on the cycle after entry into ON or OFF, i.e. in the first cycle domain_on_o/OFF outputs are visible.
- Reset mid-sequence: all outputs return to their reset values (domain powered, not isolated) asynchronously. Reset release is synchronous to clk_i.

Test Plan:
- Nominal power-down, defaults, ack falls 5 cycles after sw_en falls:
  - iso_en_o rises 1 cycle after clk_en_o falls.
  - ret_save_o high for 2 cycles, starting 4 cycles after iso_en_o rises.
  - OFF entered 5+2+1 cycles after pwr_sw_en_o falls, with a single done_o pulse.
  - busy_o=1 throughout the sequence.
- Nominal power-up from OFF, ack rises 3 cycles after sw_en:
  - ret_restore_o high 2 cycles.
  - iso_en_o falls, then clk_en_o=1 after 4 cycles.
  - domain_on_o=1 and done_o pulse.
- Ack never falls in SW_OFF:
  - err_o=1 after 256 cycles.
  - FSM re-enables pwr_sw_en_o and completes power-up to ON.
  - err_clr_i then clears err_o.
- Requests in the wrong state:
  - pu_req_i in ON, and pd_req_i during SAVE, are ignored: trace identical to the nominal run.
  - pd_req_i and pu_req_i together in OFF -> power-up only.
- rst_ni asserted in the middle of SW_OFF:
  - Outputs immediately return to reset values (pwr_sw_en_o=1, iso_en_o=0, clk_en_o=1), with no done_o pulse.
  - After release, the FSM is in ON.
- Ack glitch shorter than 1 cycle in SW_ON: no state advance unless the level is held through SYNC_STAGES flops.
